// File: rtl/rename_pkg.sv
// Shared defaults and types for the register-rename stage.
// Payload field offsets describe how decode packs the opaque payload word.
package rename_pkg;
  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;
  localparam int PAYLOAD_W_DEF = 71;

  localparam int PL_INSTR_LSB = 0;
  localparam int PL_INSTR_W   = 32;
  localparam int PL_PC_LSB    = 32;
  localparam int PL_PC_W      = 32;
  localparam int PL_CTRL_LSB  = 64;
  localparam int PL_CTRL_WR   = 64;
  localparam int PL_CTRL_LD   = 65;
  localparam int PL_CTRL_ST   = 66;

  typedef logic [$clog2(ARCH_REGS_DEF)-1:0] arch_t;
  typedef logic [$clog2(PHYS_REGS_DEF)-1:0] preg_t;
endpackage

// File: rtl/rename_freelist.sv
// Bit-vector free list: lowest-index allocate, commit-side free, one-cycle
// reload on flush, and a registered popcount of the free vector.
module rename_freelist #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 alloc,
  input  logic                 free_valid,
  input  logic [PW-1:0]        free_preg,
  input  logic                 flush,
  input  logic [PHYS_REGS-1:0] flush_vec,
  output logic [PW-1:0]        alloc_preg,
  output logic [PW:0]          free_count
);
  localparam logic [PHYS_REGS-1:0] RST_VEC =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PHYS_REGS-1:0] vec, vec_nxt;

  function automatic logic [PW:0] popcnt(input logic [PHYS_REGS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < PHYS_REGS; i++) popcnt = popcnt + (PW+1)'(v[i]);
  endfunction

  always_comb begin
    alloc_preg = '0;
    for (int i = PHYS_REGS-1; i >= 0; i--)
      if (vec[i]) alloc_preg = PW'(i);
  end

  // Frees land in vec_nxt only, so a freed preg is allocatable next cycle.
  always_comb begin
    vec_nxt = vec;
    if (flush) vec_nxt = flush_vec;
    else begin
      if (alloc) vec_nxt[alloc_preg] = 1'b0;
      if (free_valid && free_preg != '0) vec_nxt[free_preg] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vec        <= RST_VEC;
      free_count <= (PW+1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      vec        <= vec_nxt;
      free_count <= popcnt(vec_nxt);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && !flush && free_valid && free_preg != '0)
      assert (!vec[free_preg]);
  end
endmodule

// File: rtl/rename_unit.sv
// Single-issue rename stage: speculative map, busy table, free list and a
// valid/ready output register; flush restores everything from the RRAT.
module rename_unit import rename_pkg::*; #(
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int AW        = $clog2(ARCH_REGS),
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  input  logic [AW-1:0]           in_src_a,
  input  logic [AW-1:0]           in_src_b,
  input  logic [AW-1:0]           in_dst,
  input  logic                    in_wr,
  input  logic                    in_ld,
  input  logic                    in_st,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic [PW-1:0]           out_psrc_a,
  output logic [PW-1:0]           out_psrc_b,
  output logic [PW-1:0]           out_pdst,
  output logic [PW-1:0]           out_old_pdst,
  output logic                    out_a_busy,
  output logic                    out_b_busy,
  output logic                    out_to_lsq,
  output logic                    out_to_iq,
  input  logic                    commit_free_valid,
  input  logic [PW-1:0]           commit_free_preg,
  input  logic                    wb_clear_valid,
  input  logic [PW-1:0]           wb_clear_preg,
  input  logic                    flush_valid,
  input  logic [ARCH_REGS*PW-1:0] rrat_map,
  output logic [PW:0]             free_count
);
  logic [ARCH_REGS-1:0][PW-1:0] map, rrat;
  logic [PHYS_REGS-1:0]         busy, rrat_ref, flush_vec;
  logic [PW-1:0]                fl_preg, psrc_a, psrc_b, old_pdst, pdst;
  logic                         alloc, fire, do_alloc, a_busy, b_busy;

  assign rrat     = rrat_map;
  assign alloc    = (in_wr | in_ld) & (in_dst != '0);
  assign in_ready = (!out_valid | out_ready) & !flush_valid & !(alloc & (free_count == '0));
  assign fire     = in_valid & in_ready;
  assign do_alloc = fire & alloc;

  assign psrc_a   = map[in_src_a];
  assign psrc_b   = map[in_src_b];
  assign old_pdst = map[in_dst];
  assign pdst     = alloc ? fl_preg : old_pdst;
  // Writeback landing this cycle must not be reported as still busy.
  assign a_busy   = busy[psrc_a] & !(wb_clear_valid & (wb_clear_preg == psrc_a));
  assign b_busy   = busy[psrc_b] & !(wb_clear_valid & (wb_clear_preg == psrc_b));

  // Every preg not named by the retirement map is free again; preg 0 never is.
  always_comb begin
    rrat_ref = '0;
    for (int i = 0; i < ARCH_REGS; i++) rrat_ref[rrat[i]] = 1'b1;
    flush_vec    = ~rrat_ref;
    flush_vec[0] = 1'b0;
  end

  rename_freelist #(.PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS), .PW(PW)) u_freelist (
    .CLK        (CLK),
    .RESET      (RESET),
    .alloc      (do_alloc),
    .free_valid (commit_free_valid),
    .free_preg  (commit_free_preg),
    .flush      (flush_valid),
    .flush_vec  (flush_vec),
    .alloc_preg (fl_preg),
    .free_count (free_count)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) map[i] <= PW'(i);
      busy <= '0;
    end else if (flush_valid) begin
      map  <= rrat;
      busy <= '0;
    end else begin
      if (wb_clear_valid) busy[wb_clear_preg] <= 1'b0;
      if (do_alloc) begin
        busy[fl_preg] <= 1'b1;
        map[in_dst]   <= fl_preg;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      out_payload  <= '0;
      out_psrc_a   <= '0;
      out_psrc_b   <= '0;
      out_pdst     <= '0;
      out_old_pdst <= '0;
      out_a_busy   <= 1'b0;
      out_b_busy   <= 1'b0;
      out_to_lsq   <= 1'b0;
      out_to_iq    <= 1'b0;
    end else if (flush_valid) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_payload  <= in_payload;
      out_psrc_a   <= psrc_a;
      out_psrc_b   <= psrc_b;
      out_pdst     <= pdst;
      out_old_pdst <= old_pdst;
      out_a_busy   <= a_busy;
      out_b_busy   <= b_busy;
      out_to_lsq   <= in_ld | in_st;
      out_to_iq    <= !(in_ld | in_st);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && !flush_valid && do_alloc && wb_clear_valid)
      assert (wb_clear_preg != fl_preg);
  end
endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed test-plan cases pinned with
// literal values, then randomized traffic checked against a rule-level model.
module tb_rename_unit;
  localparam int AR = 32, PR = 64, PLW = 71, AW = 5, PW = 6;

  logic CLK = 1'b0, RESET = 1'b1;
  logic in_valid, in_ready, in_wr, in_ld, in_st;
  logic [PLW-1:0] in_payload, out_payload;
  logic [AW-1:0] in_src_a, in_src_b, in_dst;
  logic out_valid, out_ready, out_a_busy, out_b_busy, out_to_lsq, out_to_iq;
  logic [PW-1:0] out_psrc_a, out_psrc_b, out_pdst, out_old_pdst;
  logic commit_free_valid, wb_clear_valid, flush_valid;
  logic [PW-1:0] commit_free_preg, wb_clear_preg;
  logic [AR*PW-1:0] rrat_map;
  logic [PW:0] free_count;

  always #5 CLK = ~CLK;

  rename_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR), .PAYLOAD_W(PLW)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst),
    .in_wr(in_wr), .in_ld(in_ld), .in_st(in_st), .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_psrc_a(out_psrc_a), .out_psrc_b(out_psrc_b),
    .out_pdst(out_pdst), .out_old_pdst(out_old_pdst), .out_a_busy(out_a_busy),
    .out_b_busy(out_b_busy), .out_to_lsq(out_to_lsq), .out_to_iq(out_to_iq),
    .commit_free_valid(commit_free_valid), .commit_free_preg(commit_free_preg),
    .wb_clear_valid(wb_clear_valid), .wb_clear_preg(wb_clear_preg),
    .flush_valid(flush_valid), .rrat_map(rrat_map), .free_count(free_count)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain arrays of map, free and busy state.
  int m_map[AR];
  bit m_free[PR];
  bit m_busy[PR];
  bit m_ov;
  logic [PLW-1:0] e_pl;
  int e_psa, e_psb, e_pd, e_old;
  bit e_ab, e_bb, e_lsq, e_iq;

  task automatic model_reset();
    for (int i = 0; i < AR; i++) m_map[i] = i;
    for (int i = 0; i < PR; i++) begin m_free[i] = (i >= AR); m_busy[i] = 0; end
    m_ov = 0; e_pl = '0; e_psa = 0; e_psb = 0; e_pd = 0; e_old = 0;
    e_ab = 0; e_bb = 0; e_lsq = 0; e_iq = 0;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < PR; i++) c += m_free[i];
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < PR; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  function automatic bit m_alloc();
    return (in_wr || in_ld) && in_dst != 0;
  endfunction

  function automatic bit m_ready();
    return (!m_ov || out_ready) && !flush_valid && !(m_alloc() && m_count() == 0);
  endfunction

  task automatic model_step();
    bit fire, al;
    int pd;
    if (flush_valid) begin
      for (int i = 0; i < PR; i++) begin m_free[i] = (i != 0); m_busy[i] = 0; end
      for (int i = 0; i < AR; i++) begin
        m_map[i] = int'(rrat_map[i*PW +: PW]);
        m_free[m_map[i]] = 0;
      end
      m_ov = 0;
      return;
    end
    fire = in_valid && m_ready();
    al = m_alloc();
    pd = al ? m_lowest() : m_map[in_dst];
    if (fire) begin
      e_pl = in_payload; e_psa = m_map[in_src_a]; e_psb = m_map[in_src_b];
      e_ab = m_busy[e_psa] && !(wb_clear_valid && int'(wb_clear_preg) == e_psa);
      e_bb = m_busy[e_psb] && !(wb_clear_valid && int'(wb_clear_preg) == e_psb);
      e_old = m_map[in_dst]; e_pd = pd;
      e_lsq = in_ld || in_st; e_iq = !(in_ld || in_st);
      m_ov = 1;
    end else if (out_ready) m_ov = 0;
    if (commit_free_valid && commit_free_preg != 0) m_free[commit_free_preg] = 1;
    if (wb_clear_valid) m_busy[wb_clear_preg] = 0;
    if (fire && al) begin m_free[pd] = 0; m_busy[pd] = 1; m_map[in_dst] = pd; end
  endtask

  task automatic check_out();
    chk("out_valid", out_valid, m_ov);
    chk("free_count", free_count, m_count());
    chk("out_payload", out_payload, e_pl);
    chk("out_psrc_a", out_psrc_a, e_psa);
    chk("out_psrc_b", out_psrc_b, e_psb);
    chk("out_pdst", out_pdst, e_pd);
    chk("out_old_pdst", out_old_pdst, e_old);
    chk("out_a_busy", out_a_busy, e_ab);
    chk("out_b_busy", out_b_busy, e_bb);
    chk("out_to_lsq", out_to_lsq, e_lsq);
    chk("out_to_iq", out_to_iq, e_iq);
  endtask

  // Called with inputs set just after a falling edge.
  task automatic tick();
    #1;
    chk("in_ready", in_ready, m_ready());
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_out();
  endtask

  task automatic idle();
    in_valid = 0; in_wr = 0; in_ld = 0; in_st = 0; in_payload = '0;
    in_src_a = '0; in_src_b = '0; in_dst = '0; out_ready = 1;
    commit_free_valid = 0; commit_free_preg = '0; wb_clear_valid = 0; wb_clear_preg = '0;
    flush_valid = 0;
  endtask

  task automatic ins(input int d, input int a, input int b, input bit wr, input bit ld, input bit st);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    in_valid = 1; in_payload = r[PLW-1:0];
    in_dst = AW'(d); in_src_a = AW'(a); in_src_b = AW'(b);
    in_wr = wr; in_ld = ld; in_st = st;
  endtask

  function automatic logic [AR*PW-1:0] ident_map();
    logic [AR*PW-1:0] r;
    for (int i = 0; i < AR; i++) r[i*PW +: PW] = PW'(i);
    return r;
  endfunction

  function automatic logic [AR*PW-1:0] cur_map();
    logic [AR*PW-1:0] r;
    for (int i = 0; i < AR; i++) r[i*PW +: PW] = PW'(m_map[i]);
    return r;
  endfunction

  initial begin
    idle();
    rrat_map = ident_map();
    model_reset();
    @(negedge CLK); @(negedge CLK);
    RESET = 0;
    check_out();
    chk("rst_free_count", free_count, 32);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pdst", out_pdst, 0);

    // add r1 <- r2, r3
    ins(1, 2, 3, 1, 0, 0); tick();
    chk("add_psrc_a", out_psrc_a, 2); chk("add_psrc_b", out_psrc_b, 3);
    chk("add_pdst", out_pdst, 32); chk("add_old_pdst", out_old_pdst, 1);
    chk("add_busy_a", out_a_busy, 0); chk("add_busy_b", out_b_busy, 0);
    chk("add_free_count", free_count, 31);
    // dependent pair, then with same-cycle writeback bypass
    ins(4, 1, 0, 1, 0, 0); tick();
    chk("dep_psrc_a", out_psrc_a, 32); chk("dep_a_busy", out_a_busy, 1);
    chk("dep_pdst", out_pdst, 33);
    ins(5, 1, 0, 1, 0, 0); wb_clear_valid = 1; wb_clear_preg = 32; tick();
    chk("byp_a_busy", out_a_busy, 0); chk("byp_pdst", out_pdst, 34);
    idle();
    // write to r0 never allocates
    ins(0, 2, 3, 1, 0, 0); tick();
    chk("r0_pdst", out_pdst, 0); chk("r0_old", out_old_pdst, 0);
    chk("r0_free_count", free_count, 29);
    ins(6, 0, 0, 1, 0, 0); tick();
    chk("r0_busy", out_a_busy, 0); chk("r6_pdst", out_pdst, 35);
    // back-pressure: output holds, nothing consumed
    out_ready = 0;
    ins(7, 4, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pdst", out_pdst, 35); chk("stall_in_ready", in_ready, 0);
      chk("stall_free_count", free_count, 28);
    end
    out_ready = 1; tick();
    chk("unstall_pdst", out_pdst, 36);
    for (int i = 0; i < 5; i++) begin ins(8 + i, i, i + 1, 1, 0, 0); tick(); end
    // flush back to identity
    idle(); ins(3, 3, 3, 1, 0, 0); flush_valid = 1; rrat_map = ident_map(); tick();
    chk("flush_out_valid", out_valid, 0); chk("flush_free_count", free_count, 32);
    idle(); ins(1, 1, 2, 1, 0, 0); tick();
    chk("post_flush_pdst", out_pdst, 32); chk("post_flush_busy", out_a_busy, 0);
    // exhaust the free list
    for (int i = 0; i < 31; i++) begin ins(1 + (i % 31), 2, 3, 1, 0, 0); tick(); end
    chk("empty_free_count", free_count, 0);
    ins(0, 1, 2, 0, 0, 1); #1;
    chk("empty_store_ready", in_ready, 1);
    tick(); chk("store_to_lsq", out_to_lsq, 1);
    ins(7, 1, 2, 1, 0, 0); commit_free_valid = 1; commit_free_preg = 5; #1;
    chk("empty_write_ready", in_ready, 0);
    tick();
    commit_free_valid = 0; tick();
    chk("refill_pdst", out_pdst, 5); chk("refill_free_count", free_count, 0);
    // asynchronous reset mid-flight clears a pending output
    ins(0, 1, 2, 0, 1, 0); tick();
    idle(); #2; RESET = 1; #1;
    chk("areset_out_valid", out_valid, 0); chk("areset_free_count", free_count, 32);
    model_reset();
    @(negedge CLK); RESET = 0; check_out();

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      int cand[$];
      idle();
      if ($urandom_range(3) != 0) begin
        bit wr, ld, st;
        wr = $urandom_range(1); ld = ($urandom_range(6) == 0); st = !ld && ($urandom_range(6) == 0);
        ins($urandom_range(AR-1), $urandom_range(AR-1), $urandom_range(AR-1), wr, ld, st);
      end
      out_ready = ($urandom_range(3) != 0);
      cand.delete();
      for (int p = 1; p < PR; p++) begin
        bit mapped = 0;
        for (int a = 0; a < AR; a++) if (m_map[a] == p) mapped = 1;
        if (!m_free[p] && !mapped) cand.push_back(p);
      end
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
        commit_free_valid = 1; commit_free_preg = PW'(cand[$urandom_range(cand.size()-1)]);
      end
      cand.delete();
      for (int p = 1; p < PR; p++) if (m_busy[p] && !m_free[p]) cand.push_back(p);
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
        wb_clear_valid = 1; wb_clear_preg = PW'(cand[$urandom_range(cand.size()-1)]);
      end
      if ($urandom_range(39) == 0) begin
        flush_valid = 1;
        rrat_map = $urandom_range(1) ? ident_map() : cur_map();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
